// File: rtl/vx_result_gather_pkg.sv
// Shared widths and types for result gathering: warp header fields, the
// assembled warp result handed to commit, and the gather FSM states.
package vx_result_gather_pkg;

  localparam int XLEN            = 32;
  localparam int DEF_NUM_THREADS = 4;
  localparam int SIMD_WIDTH      = 2;
  localparam int UUID_WIDTH      = 44;
  localparam int VL_WIDTH        = 2;
  localparam int NW_WIDTH        = 2;
  localparam int PC_BITS         = 30;
  localparam int NR_BITS         = 5;

  typedef struct packed {
    logic [UUID_WIDTH-1:0] uuid;
    logic [VL_WIDTH-1:0]   lid;
    logic [NW_WIDTH-1:0]   wid;
    logic [PC_BITS-1:0]    pc;
    logic                  wb;
    logic [NR_BITS-1:0]    rd;
  } hdr_t;

  // Full-warp result as seen by commit/writeback.
  typedef struct packed {
    hdr_t                                     hdr;
    logic [DEF_NUM_THREADS-1:0]               tmask;
    logic [DEF_NUM_THREADS-1:0][XLEN-1:0]     data;
  } gather_res_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_HOLD
  } gather_state_e;

endpackage

// File: rtl/vx_result_if.sv
// Execute-unit result packet interface: one NUM_LANES-wide slice of a warp
// result per beat, framed by sop/eop and positioned by pid.
interface vx_result_if #(
  parameter int NUM_LANES = vx_result_gather_pkg::SIMD_WIDTH,
  parameter int PID_WIDTH = 1
) ();

  logic                                               valid;
  logic                                               ready;
  logic [vx_result_gather_pkg::UUID_WIDTH-1:0]        uuid;
  logic [vx_result_gather_pkg::VL_WIDTH-1:0]          lid;
  logic [vx_result_gather_pkg::NW_WIDTH-1:0]          wid;
  logic [NUM_LANES-1:0]                               tmask;
  logic [vx_result_gather_pkg::PC_BITS-1:0]           PC;
  logic                                               wb;
  logic [vx_result_gather_pkg::NR_BITS-1:0]           rd;
  logic [NUM_LANES-1:0][vx_result_gather_pkg::XLEN-1:0] data;
  logic [PID_WIDTH-1:0]                               pid;
  logic                                               sop;
  logic                                               eop;

  modport master (output valid, uuid, lid, wid, tmask, PC, wb, rd, data, pid, sop, eop,
                  input  ready);
  modport slave  (input  valid, uuid, lid, wid, tmask, PC, wb, rd, data, pid, sop, eop,
                  output ready);

endinterface

// File: rtl/vx_result_gather_merge.sv
// Combinational slice write: drops one packet's lanes into the pid-selected
// slice of the assembly buffer, leaving every other slice untouched.
module vx_result_gather_merge
  import vx_result_gather_pkg::*;
#(
  parameter int NUM_LANES   = SIMD_WIDTH,
  parameter int NUM_THREADS = DEF_NUM_THREADS,
  parameter int PID_WIDTH   = 1
) (
  input  logic                                en,
  input  logic [PID_WIDTH-1:0]                pid,
  input  logic [NUM_LANES-1:0]                pkt_tmask,
  input  logic [NUM_LANES-1:0][XLEN-1:0]      pkt_data,
  input  logic [NUM_THREADS-1:0]              cur_tmask,
  input  logic [NUM_THREADS-1:0][XLEN-1:0]    cur_data,
  output logic [NUM_THREADS-1:0]              nxt_tmask,
  output logic [NUM_THREADS-1:0][XLEN-1:0]    nxt_data
);

  localparam int NP = NUM_THREADS / NUM_LANES;

  for (genvar g = 0; g < NP; g++) begin : g_slice
    logic hit;
    if (NP == 1) begin : g_one
      // Single-slice warp: pid carries no information.
      logic unused_pid;
      assign unused_pid = ^pid;
      assign hit = en;
    end else begin : g_many
      assign hit = en && (pid == PID_WIDTH'(g));
    end
    assign nxt_tmask[g*NUM_LANES +: NUM_LANES] = hit ? pkt_tmask : cur_tmask[g*NUM_LANES +: NUM_LANES];
    assign nxt_data[g*NUM_LANES +: NUM_LANES]  = hit ? pkt_data  : cur_data[g*NUM_LANES +: NUM_LANES];
  end

endmodule

// File: rtl/vx_result_gather.sv
// Collects sop..eop result packets into one warp-wide result held in a
// ready/valid output register; flags malformed packet streams.
module vx_result_gather
  import vx_result_gather_pkg::*;
#(
  parameter int NUM_LANES   = SIMD_WIDTH,
  parameter int NUM_THREADS = DEF_NUM_THREADS,
  parameter int PID_WIDTH   = (NUM_THREADS / NUM_LANES > 1) ? $clog2(NUM_THREADS / NUM_LANES) : 1
) (
  input  logic                              clk,
  input  logic                              reset,
  vx_result_if.slave                        result_if,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [UUID_WIDTH-1:0]             out_uuid,
  output logic [VL_WIDTH-1:0]               out_lid,
  output logic [NW_WIDTH-1:0]               out_wid,
  output logic [NUM_THREADS-1:0]            out_tmask,
  output logic [PC_BITS-1:0]                out_PC,
  output logic                              out_wb,
  output logic [NR_BITS-1:0]                out_rd,
  output logic [NUM_THREADS-1:0][XLEN-1:0]  out_data,
  output logic                              protocol_err
);

  localparam int NP = NUM_THREADS / NUM_LANES;

  gather_state_e                   state, state_n;
  hdr_t                            hdr_q, hdr_n, pkt_hdr;
  logic [NUM_THREADS-1:0]          tmask_q, base_tmask, mrg_tmask;
  logic [NUM_THREADS-1:0][XLEN-1:0] data_q, base_data, mrg_data;
  logic                            err_q, err_n;
  logic                            fire, pid_bad, merge_en;

  assign result_if.ready = (state != ST_HOLD) || out_ready;
  assign fire            = result_if.valid && result_if.ready;
  assign pid_bad         = (NP > 1) && (32'(result_if.pid) >= NP);

  assign pkt_hdr = '{uuid: result_if.uuid, lid: result_if.lid, wid: result_if.wid,
                     pc: result_if.PC, wb: result_if.wb, rd: result_if.rd};

  always_comb begin
    state_n    = state;
    hdr_n      = hdr_q;
    base_tmask = tmask_q;
    base_data  = data_q;
    merge_en   = 1'b0;
    err_n      = err_q;
    // A fire while in HOLD implies out_ready, so the held result is released first.
    if (state == ST_HOLD && out_ready) state_n = ST_IDLE;
    if (fire) begin
      if (result_if.sop) begin
        if (state == ST_COLLECT) err_n = 1'b1;
        hdr_n      = pkt_hdr;
        base_tmask = '0;
        base_data  = '0;
        merge_en   = !pid_bad;
        if (pid_bad) err_n = 1'b1;
        state_n    = result_if.eop ? ST_HOLD : ST_COLLECT;
      end else if (state == ST_COLLECT) begin
        if (result_if.wid != hdr_q.wid) err_n = 1'b1;
        merge_en = !pid_bad;
        if (pid_bad) err_n = 1'b1;
        state_n  = result_if.eop ? ST_HOLD : ST_COLLECT;
      end else begin
        err_n = 1'b1;
      end
    end
  end

  vx_result_gather_merge #(
    .NUM_LANES   (NUM_LANES),
    .NUM_THREADS (NUM_THREADS),
    .PID_WIDTH   (PID_WIDTH)
  ) merge (
    .en        (merge_en),
    .pid       (result_if.pid),
    .pkt_tmask (result_if.tmask),
    .pkt_data  (result_if.data),
    .cur_tmask (base_tmask),
    .cur_data  (base_data),
    .nxt_tmask (mrg_tmask),
    .nxt_data  (mrg_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      hdr_q   <= '0;
      tmask_q <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_n;
      hdr_q   <= hdr_n;
      tmask_q <= mrg_tmask;
      data_q  <= mrg_data;
      err_q   <= err_n;
    end
  end

  assign out_valid    = (state == ST_HOLD);
  assign out_uuid     = hdr_q.uuid;
  assign out_lid      = hdr_q.lid;
  assign out_wid      = hdr_q.wid;
  assign out_PC       = hdr_q.pc;
  assign out_wb       = hdr_q.wb;
  assign out_rd       = hdr_q.rd;
  assign out_tmask    = tmask_q;
  assign out_data     = data_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_vx_result_gather.sv
// Directed and random checks of vx_result_gather with 4 threads, 2 lanes.
module tb_vx_result_gather;
  import vx_result_gather_pkg::*;

  localparam int NT = 4;
  localparam int NL = 2;
  localparam int PW = 1;

  typedef struct packed {
    hdr_t                      hdr;
    logic [NL-1:0]             tmask;
    logic [NL-1:0][XLEN-1:0]   data;
    logic                      pid;
    logic                      sop;
    logic                      eop;
  } pkt_t;

  typedef struct packed {
    hdr_t                      hdr;
    logic [NT-1:0]             tmask;
    logic [NT-1:0][XLEN-1:0]   data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic out_valid, out_ready, out_wb, protocol_err;
  logic [UUID_WIDTH-1:0] out_uuid;
  logic [VL_WIDTH-1:0]   out_lid;
  logic [NW_WIDTH-1:0]   out_wid;
  logic [NT-1:0]         out_tmask;
  logic [PC_BITS-1:0]    out_PC;
  logic [NR_BITS-1:0]    out_rd;
  logic [NT-1:0][XLEN-1:0] out_data;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  vx_result_if #(.NUM_LANES(NL), .PID_WIDTH(PW)) rif ();

  vx_result_gather #(.NUM_LANES(NL), .NUM_THREADS(NT), .PID_WIDTH(PW)) dut (
    .clk          (clk),
    .reset        (reset),
    .result_if    (rif),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_uuid     (out_uuid),
    .out_lid      (out_lid),
    .out_wid      (out_wid),
    .out_tmask    (out_tmask),
    .out_PC       (out_PC),
    .out_wb       (out_wb),
    .out_rd       (out_rd),
    .out_data     (out_data),
    .protocol_err (protocol_err)
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input pkt_t p);
    rif.valid = 1'b1;
    rif.uuid  = p.hdr.uuid;
    rif.lid   = p.hdr.lid;
    rif.wid   = p.hdr.wid;
    rif.PC    = p.hdr.pc;
    rif.wb    = p.hdr.wb;
    rif.rd    = p.hdr.rd;
    rif.tmask = p.tmask;
    rif.data  = p.data;
    rif.pid   = p.pid;
    rif.sop   = p.sop;
    rif.eop   = p.eop;
  endtask

  function automatic hdr_t out_hdr();
    hdr_t h;
    h = '{uuid: out_uuid, lid: out_lid, wid: out_wid, pc: out_PC, wb: out_wb, rd: out_rd};
    return h;
  endfunction

  function automatic hdr_t rnd_hdr();
    hdr_t h;
    h.uuid = {12'($urandom), $urandom};
    h.lid  = 2'($urandom);
    h.wid  = 2'($urandom);
    h.pc   = 30'($urandom);
    h.wb   = 1'($urandom);
    h.rd   = 5'($urandom);
    return h;
  endfunction

  function automatic pkt_t rnd_pkt(input hdr_t h, input logic pid, input logic sop, input logic eop);
    pkt_t p;
    p.hdr   = h;
    p.tmask = 2'($urandom);
    p.data[0] = $urandom;
    p.data[1] = $urandom;
    p.pid = pid;
    p.sop = sop;
    p.eop = eop;
    return p;
  endfunction

  // Reference: place a packet's lanes at its pid slice.
  function automatic exp_t apply(input exp_t e, input pkt_t p);
    exp_t r;
    int b;
    r = e;
    b = int'(p.pid) * NL;
    for (int l = 0; l < NL; l++) begin
      r.tmask[b+l] = p.tmask[l];
      r.data[b+l]  = p.data[l];
    end
    return r;
  endfunction

  initial begin
    hdr_t ha, hb, hc;
    pkt_t p0, p1, p1w, p2, pg, pi;
    logic [NT-1:0][XLEN-1:0] exp_d;
    pkt_t pq[$];
    exp_t expq[$];
    exp_t e;
    hdr_t h;
    int k, cyc, nout;
    logic fired;

    ha = '{uuid: 44'h123_4567_89ab, lid: 2'd1, wid: 2'd2, pc: 30'h0000_1000, wb: 1'b1, rd: 5'd5};
    hb = '{uuid: 44'h0ff_0000_0001, lid: 2'd3, wid: 2'd2, pc: 30'h0000_2000, wb: 1'b0, rd: 5'd9};
    hc = '{uuid: 44'h0aa_0000_0002, lid: 2'd0, wid: 2'd1, pc: 30'h0000_3000, wb: 1'b1, rd: 5'd17};
    p0  = '{hdr: ha, tmask: 2'b11, data: {32'h0000_00B0, 32'h0000_00A0}, pid: 1'b0, sop: 1'b1, eop: 1'b0};
    p1  = '{hdr: hb, tmask: 2'b01, data: {32'h0000_00D0, 32'h0000_00C0}, pid: 1'b1, sop: 1'b0, eop: 1'b1};
    p1w = p1;
    p1w.hdr.wid = 2'd3;
    p2  = '{hdr: hc, tmask: 2'b10, data: {32'h0000_00F0, 32'h0000_00E0}, pid: 1'b1, sop: 1'b1, eop: 1'b1};
    pg  = '{hdr: hb, tmask: 2'b11, data: {32'h0000_0081, 32'h0000_0071}, pid: 1'b1, sop: 1'b1, eop: 1'b0};
    pi  = '{hdr: hb, tmask: 2'b01, data: {32'h0000_0061, 32'h0000_0051}, pid: 1'b0, sop: 1'b0, eop: 1'b1};

    reset = 1'b1;
    out_ready = 1'b0;
    rif.valid = 1'b0;
    drive(p0);
    rif.valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    chk("rst_valid", 512'(out_valid), 512'(1'b0));
    chk("rst_err", 512'(protocol_err), 512'(1'b0));
    chk("rst_tmask", 512'(out_tmask), 512'(4'b0000));
    chk("rst_data", 512'(out_data), 512'(0));
    chk("rst_hdr", 512'(out_hdr()), 512'(0));
    chk("rst_ready", 512'(rif.ready), 512'(1'b1));

    // Two-packet warp.
    drive(p0);
    tick();
    chk("two_mid_valid", 512'(out_valid), 512'(1'b0));
    drive(p1);
    tick();
    rif.valid = 1'b0;
    exp_d = {32'h0000_00D0, 32'h0000_00C0, 32'h0000_00B0, 32'h0000_00A0};
    chk("two_valid", 512'(out_valid), 512'(1'b1));
    chk("two_tmask", 512'(out_tmask), 512'(4'b0111));
    chk("two_data", 512'(out_data), 512'(exp_d));
    chk("two_hdr", 512'(out_hdr()), 512'(ha));

    // Back-pressure with a waiting sop&&eop at pid1.
    drive(p2);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_ready", 512'(rif.ready), 512'(1'b0));
      tick();
      chk("bp_tmask", 512'(out_tmask), 512'(4'b0111));
      chk("bp_data", 512'(out_data), 512'(exp_d));
    end
    out_ready = 1'b1;
    #1;
    chk("rel_ready", 512'(rif.ready), 512'(1'b1));
    tick();
    rif.valid = 1'b0;
    exp_d = {32'h0000_00F0, 32'h0000_00E0, 32'h0, 32'h0};
    chk("hi_valid", 512'(out_valid), 512'(1'b1));
    chk("hi_tmask", 512'(out_tmask), 512'(4'b1000));
    chk("hi_data", 512'(out_data), 512'(exp_d));
    chk("hi_hdr", 512'(out_hdr()), 512'(hc));
    chk("hi_err", 512'(protocol_err), 512'(1'b0));
    tick();
    chk("drain_valid", 512'(out_valid), 512'(1'b0));

    // Stray non-sop in IDLE.
    drive(p1);
    tick();
    rif.valid = 1'b0;
    chk("stray_valid", 512'(out_valid), 512'(1'b0));
    chk("stray_err", 512'(protocol_err), 512'(1'b1));
    tick();
    chk("stray_nout", 512'(out_valid), 512'(1'b0));

    // Restart on sop during COLLECT.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive(p0);
    tick();
    chk("rs_err0", 512'(protocol_err), 512'(1'b0));
    drive(pg);
    tick();
    chk("rs_err1", 512'(protocol_err), 512'(1'b1));
    drive(pi);
    tick();
    rif.valid = 1'b0;
    exp_d = {32'h0000_0081, 32'h0000_0071, 32'h0000_0061, 32'h0000_0051};
    chk("rs_valid", 512'(out_valid), 512'(1'b1));
    chk("rs_tmask", 512'(out_tmask), 512'(4'b1101));
    chk("rs_data", 512'(out_data), 512'(exp_d));
    chk("rs_hdr", 512'(out_hdr()), 512'(hb));
    tick();

    // Reset mid-COLLECT drops the warp.
    drive(p0);
    tick();
    rif.valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rc_valid", 512'(out_valid), 512'(1'b0));
    chk("rc_err", 512'(protocol_err), 512'(1'b0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rc_nout", 512'(out_valid), 512'(1'b0));
    end

    // wid mismatch inside a warp: still merged, flagged.
    drive(p0);
    tick();
    drive(p1w);
    tick();
    rif.valid = 1'b0;
    chk("wid_valid", 512'(out_valid), 512'(1'b1));
    chk("wid_tmask", 512'(out_tmask), 512'(4'b0111));
    chk("wid_err", 512'(protocol_err), 512'(1'b1));

    // Random warps with random back-pressure.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int w = 0; w < 1000; w++) begin
      h = rnd_hdr();
      e = '0;
      e.hdr = h;
      k = $urandom_range(0, 2);
      if (k == 0) begin
        p0 = rnd_pkt(h, 1'b0, 1'b1, 1'b0);
        p1 = rnd_pkt(rnd_hdr(), 1'b1, 1'b0, 1'b1);
        p1.hdr.wid = h.wid;
        pq.push_back(p0);
        pq.push_back(p1);
        e = apply(e, p0);
        e = apply(e, p1);
      end else begin
        p0 = rnd_pkt(h, (k == 2), 1'b1, 1'b1);
        pq.push_back(p0);
        e = apply(e, p0);
      end
      expq.push_back(e);
    end
    cyc = 0;
    nout = 0;
    while (nout < 1000 && cyc < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (pq.size() > 0 && $urandom_range(0, 4) != 0) drive(pq[0]);
      else rif.valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        e = expq.pop_front();
        chk("rand_result", 512'({out_hdr(), out_tmask, out_data}), 512'(e));
        nout++;
      end
      fired = rif.valid && rif.ready;
      tick();
      if (fired) void'(pq.pop_front());
      cyc++;
    end
    rif.valid = 1'b0;
    chk("rand_count", 512'(nout), 512'(1000));
    chk("rand_err", 512'(protocol_err), 512'(1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
